// File: rtl/scan8_4b_if.sv
// rtl/scan8_4b_if.sv - write/scan control inputs and mux-facing outputs of scan8_4b
interface scan8_4b_if;
  logic       we;
  logic [2:0] waddr;
  logic [3:0] wdata;
  logic       en;
  logic       step;
  logic [3:0] i0, i1, i2, i3, i4, i5, i6, i7;
  logic [2:0] s;
  logic       tick;
  logic       frame;

  modport master (
    output we, waddr, wdata, en, step,
    input  i0, i1, i2, i3, i4, i5, i6, i7, s, tick, frame
  );

  modport slave (
    input  we, waddr, wdata, en, step,
    output i0, i1, i2, i3, i4, i5, i6, i7, s, tick, frame
  );
endinterface

// File: rtl/scan8_4b.sv
// rtl/scan8_4b.sv - 8x4-bit register bank with cyclic 3-bit select for an 8:1 nibble mux
module scan8_4b #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  scan8_4b_if.slave   bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

  logic [3:0]    bank [8];
  logic [CW-1:0] cnt;
  logic [2:0]    s_q;
  logic          tick_q;
  logic          frame_q;
  logic          advance;

  // step only counts while the dwell counter is stopped
  assign advance = bus.en ? (cnt == CMAX) : bus.step;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) bank[k] <= 4'h0;
    end else if (bus.we) begin
      bank[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      s_q     <= 3'd0;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      if (bus.en)
        cnt <= (cnt == CMAX) ? '0 : cnt + 1'b1;
      else if (bus.step)
        cnt <= '0;
      if (advance)
        s_q <= s_q + 3'd1;
      tick_q  <= advance;
      frame_q <= advance && (s_q == 3'd7);
    end
  end

  assign bus.i0    = bank[0];
  assign bus.i1    = bank[1];
  assign bus.i2    = bank[2];
  assign bus.i3    = bank[3];
  assign bus.i4    = bank[4];
  assign bus.i5    = bank[5];
  assign bus.i6    = bank[6];
  assign bus.i7    = bank[7];
  assign bus.s     = s_q;
  assign bus.tick  = tick_q;
  assign bus.frame = frame_q;
endmodule
